// File: rtl/knn_majority_vote.sv
// knn_majority_vote
//
// Majority vote stage after the bitonic distance sorter in the KNN system.
// It captures one sorted vector of distances and class types. It then takes
// the K nearest entries, one per cycle, and tallies the votes per class.
// Next it scans the NC class tallies, one per cycle, to find the majority
// class. The result is returned over a valid/ready handshake.
//
// Parameters
//   L       log2 of the entry count; N = 1 << L
//   W       distance width; distances are registered for debug only
//   TYPE_W  class-type width; NC = 1 << TYPE_W classes
//   K       neighbours voted, 1 <= K <= N
//   CW      vote-count width, $clog2(K+1)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   sorted vector present (sorter out_valid pulse, cannot stall)
//   ascending  1: nearest entry at index 0, 0: nearest entry at index N-1
//   in         sorted distances, entry i = in[W*(i+1)-1 -: W]
//   in_type    class of each entry, same indexing as in
//   in_ready   high only while idle
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts the result
//   out_class  majority class (kept after acceptance)
//   out_count  votes for out_class (kept after acceptance)
//   overrun    sticky: a vector arrived while in_ready was low; cleared by rst only
//
// Build option
//   KNN_VOTE_TIE_NEAREST_EN  When defined, a tie between classes goes to the
//                            class that holds the nearest neighbour among the
//                            tied classes. When undefined, a tie goes to the
//                            lowest class index.
//
// Timing: capture edge T, tally edges T+1..T+K, scan edges T+K+1..T+K+NC.
// out_valid is high in the cycle that starts at edge T+K+NC.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | in_ready=1, waiting for a sorted vector
// COUNT  | K cycles, one neighbour tallied per cycle (idx = 0..K-1)
// ARGMAX | NC cycles, class cls compared against the running best
// DONE   | out_valid=1 until out_ready

module knn_majority_vote #(
    parameter int L      = 4,
    parameter int W      = 16,
    parameter int TYPE_W = 3,
    parameter int K      = 5,
    localparam int CW    = $clog2(K + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic                        ascending,
    input  logic [W*(1<<L)-1:0]         in,
    input  logic [TYPE_W*(1<<L)-1:0]    in_type,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [TYPE_W-1:0]           out_class,
    output logic [CW-1:0]               out_count,
    output logic                        overrun
);

    localparam int N  = 1 << L;
    localparam int NC = 1 << TYPE_W;

    if (K < 1 || K > N) begin : g_k_check
        $error("knn_majority_vote: K=%0d outside legal range 1..%0d", K, N);
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_ARGMAX = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    logic [L-1:0]           idx;
    logic [TYPE_W-1:0]      cls;
    logic                   asc_q;
    logic [W*N-1:0]         dist_q;
    logic [TYPE_W*N-1:0]    type_q;
    logic [CW-1:0]          tally [NC];
    logic [TYPE_W-1:0]      best_class;
    logic [CW-1:0]          best_count;

    logic                   capture;
    logic                   last_idx;
    logic                   last_cls;
    logic [L-1:0]           entry;
    logic [TYPE_W-1:0]      entry_type;
    logic                   take;

`ifdef KNN_VOTE_TIE_NEAREST_EN
    logic [L-1:0]           first_rank [NC];
    logic [L-1:0]           best_rank;
`endif

    // Distances are kept only so they can be inspected while debugging.
    logic unused_dist;
    assign unused_dist = ^dist_q;

    assign in_ready = (state == S_IDLE);
    assign capture  = in_valid && in_ready;
    assign last_idx = (idx == L'(K - 1));
    assign last_cls = (cls == {TYPE_W{1'b1}});

    // N-1-idx is the bitwise complement of idx because N is a power of two.
    assign entry      = asc_q ? idx : ~idx;
    assign entry_type = type_q[entry*TYPE_W +: TYPE_W];

`ifdef KNN_VOTE_TIE_NEAREST_EN
    // A zero tally never takes a tie. Any class with votes beats it outright.
    assign take = (tally[cls] > best_count) ||
                  ((tally[cls] == best_count) && (tally[cls] != '0) &&
                   (first_rank[cls] < best_rank));
`else
    assign take = (tally[cls] > best_count);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_nx = S_COUNT;
                end
            end
            S_COUNT: begin
                if (last_idx) begin
                    state_nx = S_ARGMAX;
                end
            end
            S_ARGMAX: begin
                if (last_cls) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            cls        <= '0;
            asc_q      <= 1'b0;
            dist_q     <= '0;
            type_q     <= '0;
            best_class <= '0;
            best_count <= '0;
            out_class  <= '0;
            out_count  <= '0;
            overrun    <= 1'b0;
            for (int c = 0; c < NC; c++) begin
                tally[c] <= '0;
            end
`ifdef KNN_VOTE_TIE_NEAREST_EN
            best_rank <= '1;
            for (int c = 0; c < NC; c++) begin
                first_rank[c] <= '1;
            end
`endif
        end else begin
            // The sorter cannot stall, so a vector that arrives while busy is lost.
            if (in_valid && !in_ready) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (capture) begin
                        asc_q      <= ascending;
                        dist_q     <= in;
                        type_q     <= in_type;
                        idx        <= '0;
                        cls        <= '0;
                        best_class <= '0;
                        best_count <= '0;
                        for (int c = 0; c < NC; c++) begin
                            tally[c] <= '0;
                        end
`ifdef KNN_VOTE_TIE_NEAREST_EN
                        best_rank <= '1;
`endif
                    end
                end
                S_COUNT: begin
                    tally[entry_type] <= tally[entry_type] + CW'(1);
`ifdef KNN_VOTE_TIE_NEAREST_EN
                    if (tally[entry_type] == '0) begin
                        first_rank[entry_type] <= idx;
                    end
`endif
                    idx <= idx + L'(1);
                end
                S_ARGMAX: begin
                    if (take) begin
                        best_class <= cls;
                        best_count <= tally[cls];
`ifdef KNN_VOTE_TIE_NEAREST_EN
                        best_rank  <= first_rank[cls];
`endif
                    end
                    // The output registers load on the last scan edge and then
                    // hold their value through DONE and after acceptance.
                    if (last_cls) begin
                        out_class <= take ? cls        : best_class;
                        out_count <= take ? tally[cls] : best_count;
                    end
                    cls <= cls + TYPE_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knn_majority_vote.sv
// Scoreboard bench for knn_majority_vote. It drives a K=5 instance and a K=1
// instance. Expected results come from a plain reference vote, or from
// hand-derived constants for the directed cases.

module tb_knn_majority_vote;

    localparam int L      = 4;
    localparam int W      = 16;
    localparam int TYPE_W = 3;
    localparam int K      = 5;
    localparam int K1     = 1;
    localparam int N      = 1 << L;
    localparam int NC     = 1 << TYPE_W;
    localparam int CW     = $clog2(K + 1);
    localparam int CW1    = $clog2(K1 + 1);

    typedef struct {
        int cls;
        int cnt;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                     in_valid, ascending, out_ready;
    logic [W*N-1:0]           in_data;
    logic [TYPE_W*N-1:0]      in_type;
    logic                     in_ready, out_valid, overrun;
    logic [TYPE_W-1:0]        out_class;
    logic [CW-1:0]            out_count;

    logic                     k1_in_valid, k1_ascending, k1_out_ready;
    logic [W*N-1:0]           k1_in_data;
    logic [TYPE_W*N-1:0]      k1_in_type;
    logic                     k1_in_ready, k1_out_valid, k1_overrun;
    logic [TYPE_W-1:0]        k1_out_class;
    logic [CW1-1:0]           k1_out_count;

    knn_majority_vote #(.L(L), .W(W), .TYPE_W(TYPE_W), .K(K)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .ascending(ascending), .in(in_data), .in_type(in_type),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_count(out_count), .overrun(overrun)
    );

    knn_majority_vote #(.L(L), .W(W), .TYPE_W(TYPE_W), .K(K1)) dut_k1 (
        .clk(clk), .rst(rst),
        .in_valid(k1_in_valid), .ascending(k1_ascending), .in(k1_in_data), .in_type(k1_in_type),
        .in_ready(k1_in_ready), .out_valid(k1_out_valid), .out_ready(k1_out_ready),
        .out_class(k1_out_class), .out_count(k1_out_count), .overrun(k1_overrun)
    );

    res_t exp_q[$];
    res_t exp1_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference vote: count the classes of the k nearest entries and take the max.
    // Ties go to the lowest class, or with the tie option to the class seen first
    // in nearest-first order.
    function automatic res_t ref_vote(input logic [TYPE_W*N-1:0] types, input bit asc, input int k);
        int   votes[NC];
        int   order[$];
        res_t r;
        for (int c = 0; c < NC; c++) votes[c] = 0;
        for (int rank = 0; rank < k; rank++) begin
            int pos;
            int t;
            pos = asc ? rank : N - 1 - rank;
            t   = int'(types[pos*TYPE_W +: TYPE_W]);
            votes[t]++;
            order.push_back(t);
        end
        r.cnt = 0;
        for (int c = 0; c < NC; c++) if (votes[c] > r.cnt) r.cnt = votes[c];
        r.cls = -1;
`ifdef KNN_VOTE_TIE_NEAREST_EN
        foreach (order[i]) if (r.cls < 0 && votes[order[i]] == r.cnt) r.cls = order[i];
`else
        for (int c = 0; c < NC; c++) if (r.cls < 0 && votes[c] == r.cnt) r.cls = c;
`endif
        return r;
    endfunction

    function automatic logic [W*N-1:0] rand_dist();
        logic [W*N-1:0] v;
        for (int i = 0; i < W*N/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [TYPE_W*N-1:0] rand_types(input int max_cls);
        logic [TYPE_W*N-1:0] v;
        for (int i = 0; i < N; i++) v[i*TYPE_W +: TYPE_W] = TYPE_W'($urandom_range(max_cls));
        return v;
    endfunction

    // Places near[0..4] at the five nearest positions and fills the rest.
    function automatic logic [TYPE_W*N-1:0] build(input bit asc, input int near[5], input int fill);
        logic [TYPE_W*N-1:0] v;
        for (int i = 0; i < N; i++) v[i*TYPE_W +: TYPE_W] = TYPE_W'(fill);
        for (int r = 0; r < 5; r++) v[(asc ? r : N - 1 - r)*TYPE_W +: TYPE_W] = TYPE_W'(near[r]);
        return v;
    endfunction

    function automatic res_t mk(input int c, input int n);
        res_t r;
        r.cls = c;
        r.cnt = n;
        return r;
    endfunction

    // Monitors: pop the expected result whenever a result is accepted.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("k5_unexpected_result", 1, 0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("k5_out_class", int'(out_class), e.cls);
                check("k5_out_count", int'(out_count), e.cnt);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && k1_out_valid && k1_out_ready) begin
            if (exp1_q.size() == 0) begin
                check("k1_unexpected_result", 1, 0);
            end else begin
                res_t e;
                e = exp1_q.pop_front();
                check("k1_out_class", int'(k1_out_class), e.cls);
                check("k1_out_count", int'(k1_out_count), e.cnt);
            end
        end
    end

    // Issue a vector and wait for out_valid. lat counts the edges after the capture edge.
    task automatic start_vec(input logic [TYPE_W*N-1:0] types, input bit asc, input res_t e);
        int lat;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        ascending = asc;
        in_type   = types;
        in_data   = rand_dist();
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("k5_latency", lat, K + NC);
    endtask

    task automatic accept(input int hold);
        repeat (hold) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_k1(input logic [TYPE_W*N-1:0] types, input bit asc, input res_t e);
        int lat;
        @(posedge clk); #1;
        k1_in_valid  = 1'b1;
        k1_ascending = asc;
        k1_in_type   = types;
        k1_in_data   = rand_dist();
        exp1_q.push_back(e);
        @(posedge clk); #1;
        k1_in_valid = 1'b0;
        lat = 0;
        while (!k1_out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("k1_latency", lat, K1 + NC);
        k1_out_ready = 1'b1;
        @(posedge clk); #1;
        k1_out_ready = 1'b0;
    endtask

    int n1[5] = '{2, 2, 1, 2, 3};
    int n2[5] = '{4, 0, 4, 6, 4};
    int n3[5] = '{3, 1, 1, 3, 0};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TYPE_W*N-1:0] t;
        logic [TYPE_W*N-1:0] t2;
        res_t e;
        bit   asc;
        rst = 1'b1;
        in_valid = 1'b0; ascending = 1'b0; out_ready = 1'b0; in_data = '0; in_type = '0;
        k1_in_valid = 1'b0; k1_ascending = 1'b0; k1_out_ready = 1'b0; k1_in_data = '0; k1_in_type = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_class", int'(out_class), 0);
        check("reset_out_count", int'(out_count), 0);
        check("reset_overrun", int'(overrun), 0);
        rst = 1'b0;

        // 1: ascending, nearest types 2,2,1,2,3 -> class 2 with 3 votes
        start_vec(build(1'b1, n1, 7), 1'b1, mk(2, 3));
        accept(0);

        // 2: descending; the 1s at the low indices are far entries and must be ignored
        start_vec(build(1'b0, n2, 1), 1'b0, mk(4, 3));
        accept(1);

        // 3: tie between 1 and 3
`ifdef KNN_VOTE_TIE_NEAREST_EN
        start_vec(build(1'b1, n3, 5), 1'b1, mk(3, 2));
`else
        start_vec(build(1'b1, n3, 5), 1'b1, mk(1, 2));
`endif
        accept(2);

        // 4: backpressure for 10 cycles; a vector arriving then is dropped and sets overrun
        start_vec(build(1'b1, n1, 7), 1'b1, mk(2, 3));
        for (int i = 0; i < 10; i++) begin
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_out_class", int'(out_class), 2);
            check("hold_in_ready", int'(in_ready), 0);
            if (i == 4) begin
                in_valid = 1'b1; ascending = 1'b1; in_type = build(1'b1, n3, 6);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("overrun_set", int'(overrun), 1);
        accept(0);
        check("after_accept_out_valid", int'(out_valid), 0);
        check("after_accept_keep_class", int'(out_class), 2);
        check("after_accept_keep_count", int'(out_count), 3);
        check("after_accept_in_ready", int'(in_ready), 1);

        // 5: reset during COUNT (idx=2) aborts with no result
        @(posedge clk); #1;
        in_valid = 1'b1; ascending = 1'b1; in_type = build(1'b1, n1, 7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_out_count", int'(out_count), 0);
        check("midreset_overrun", int'(overrun), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset_in_ready", int'(in_ready), 1);
        t = rand_types(NC - 1);
        start_vec(t, 1'b1, ref_vote(t, 1'b1, K));
        accept(0);

        // Random vectors; the narrow class range makes ties common.
        for (int i = 0; i < 24; i++) begin
            asc = 1'($urandom_range(1));
            t   = rand_types($urandom_range(1) ? 2 : NC - 1);
            start_vec(t, asc, ref_vote(t, asc, K));
            accept($urandom_range(3));
        end
        check("k5_no_overrun_without_drop", int'(overrun), 0);

        // 6: K=1, nearest entry class 7
        t2 = rand_types(3);
        t2[0 +: TYPE_W] = 3'd7;
        run_k1(t2, 1'b1, mk(7, 1));
        for (int i = 0; i < 6; i++) begin
            asc = 1'($urandom_range(1));
            t   = rand_types(NC - 1);
            run_k1(t, asc, ref_vote(t, asc, K1));
        end

        repeat (3) @(posedge clk);
        #1;
        check("k5_queue_drained", exp_q.size(), 0);
        check("k1_queue_drained", exp1_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
